// File: rtl/maze_run_controller.sv
// Sequencer between user start/run controls and the rat_in_maze solver core.
// Records the solver's path in a push/pop buffer and replays it in forward order.
module maze_run_controller #(
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    output logic             solver_start,
    input  logic             solver_push,
    input  logic             solver_pop,
    input  logic [1:0]       solver_move,
    input  logic             solver_done,
    input  logic             solver_fail,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             overflow,
    output logic [1:0]       move,
    output logic             move_valid,
    output logic [PTR_W:0]   path_len
);
    localparam int DEPTH = 1 << PTR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_SOLVING = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_REPLAY  = 3'd4;
    localparam logic [2:0] S_FAILED  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             ovf_q, ovf_d;
    logic             sstart_q, sstart_d;
    logic             busy_q, busy_d;
    logic             mv_q, mv_d;
    logic [1:0]       move_q, move_d;

    logic [1:0]       mem [DEPTH];
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [PTR_W:0]   cnt_dec;
    logic             full, empty, last, push_full;

    // count never exceeds DEPTH, so its top bit alone flags a full buffer
    assign full    = count_q[PTR_W];
    assign empty   = (count_q == '0);
    assign cnt_dec = count_q - (PTR_W+1)'(1);
    assign last    = ({1'b0, idx_q} == cnt_dec);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        done_d    = done_q;
        fail_d    = fail_q;
        ovf_d     = ovf_q;
        sstart_d  = 1'b0;
        mv_d      = 1'b0;
        move_d    = move_q;
        we        = 1'b0;
        waddr     = count_q[PTR_W-1:0];
        push_full = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_SOLVING;
            end
            S_SOLVING: begin
                if (solver_push) begin
                    if (solver_pop && !empty) begin
                        we    = 1'b1;
                        waddr = cnt_dec[PTR_W-1:0];
                    end else if (!full) begin
                        we      = 1'b1;
                        count_d = count_q + (PTR_W+1)'(1);
                    end else begin
                        push_full = 1'b1;
                        ovf_d     = 1'b1;
                    end
                end else if (solver_pop && !empty) begin
                    count_d = cnt_dec;
                end

                if (push_full || solver_fail) begin
                    fail_d  = 1'b1;
                    state_d = S_FAILED;
                end else if (solver_done) begin
                    done_d  = 1'b1;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_LAUNCH;
                end else if (run && !empty) begin
                    state_d = S_REPLAY;
                    idx_d   = '0;
                end
            end
            S_REPLAY: begin
                mv_d   = 1'b1;
                move_d = mem[idx_q];
                idx_d  = idx_q + PTR_W'(1);
                if (last) state_d = S_READY;
            end
            S_FAILED: begin
                if (start) state_d = S_LAUNCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // every entry into LAUNCH starts a fresh solve with cleared status
        if (state_d == S_LAUNCH && state_q != S_LAUNCH) begin
            sstart_d = 1'b1;
            count_d  = '0;
            done_d   = 1'b0;
            fail_d   = 1'b0;
            ovf_d    = 1'b0;
        end

        busy_d = (state_d == S_LAUNCH) || (state_d == S_SOLVING) || (state_d == S_REPLAY);
    end

    always_ff @(posedge clk) begin
        if (we && !rst) mem[waddr] <= solver_move;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sstart_q <= 1'b0;
            busy_q   <= 1'b0;
            mv_q     <= 1'b0;
            move_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            ovf_q    <= ovf_d;
            sstart_q <= sstart_d;
            busy_q   <= busy_d;
            mv_q     <= mv_d;
            move_q   <= move_d;
        end
    end

    assign solver_start = sstart_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign overflow     = ovf_q;
    assign move         = move_q;
    assign move_valid   = mv_q;
    assign path_len     = count_q;

endmodule
